// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between the icache and decode, with flush and async reset
//   clk       clock
//   reset_    asynchronous active-low reset; clears pointers, occupancy and storage
//   flush_    active-low synchronous flush on redirect; empties the queue
//   ic_e_     active-low icache response valid
//   ic_pc     PC of slot 0 of the response group
//   ic_inst   FETCH instructions, slot i at [i*INST +: INST]
//   ic_cnt    valid slots in the group (values above FETCH are clamped)
//   fq_stall  fewer than FETCH free entries; the icache must hold its response
//   dec_cnt   instructions presented to decode, min(count, DEC)
//   dec_inst  DEC head instructions, slot j = entry head+j
//   dec_pc    PC of each presented slot
//   dec_ack   instructions consumed by decode; the excess over dec_cnt is ignored
//   fq_count  current occupancy
module fetch_queue #(
   parameter int ADDR  = 32,
   parameter int INST  = 32,
   parameter int FETCH = 2,
   parameter int DEC   = 2,
   parameter int DEPTH = 8,
   localparam int CW = $clog2(FETCH + 1),
   localparam int DW = $clog2(DEC + 1),
   localparam int QW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              flush_,
   input  logic              ic_e_,
   input  logic [ADDR-1:0]   ic_pc,
   input  logic [FETCH*INST-1:0] ic_inst,
   input  logic [CW-1:0]     ic_cnt,
   output logic              fq_stall,
   output logic [DW-1:0]     dec_cnt,
   output logic [DEC*INST-1:0] dec_inst,
   output logic [DEC*ADDR-1:0] dec_pc,
   input  logic [DW-1:0]     dec_ack,
   output logic [QW-1:0]     fq_count
);
   localparam int PW = $clog2(DEPTH);
   logic [INST-1:0] inst_q [DEPTH];
   logic [ADDR-1:0] pc_q [DEPTH];
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [QW-1:0]   count_q, count_d;
   logic [CW-1:0]   push_n;
   logic [DW-1:0]   pop_n;
   logic            push;
   // Stall looks only at registered occupancy, so no input reaches any output.
   assign fq_stall = count_q > QW'(DEPTH - FETCH);
   assign fq_count = count_q;
   assign dec_cnt  = (count_q < QW'(DEC)) ? DW'(count_q) : DW'(DEC);
   assign push     = !ic_e_ && !fq_stall && flush_;
   assign push_n   = (ic_cnt > CW'(FETCH)) ? CW'(FETCH) : ic_cnt;
   assign pop_n    = (dec_ack < dec_cnt) ? dec_ack : dec_cnt;
   always_comb begin
      head_d  = flush_ ? head_q + PW'(pop_n) : '0;
      tail_d  = !flush_ ? '0 : push ? tail_q + PW'(push_n) : tail_q;
      count_d = flush_ ? count_q + (push ? QW'(push_n) : '0) - QW'(pop_n) : '0;
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            inst_q[k] <= '0;
            pc_q[k]   <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         // Pointer-width index arithmetic wraps a group straddling the last entry back to entry 0.
         for (int i = 0; i < FETCH; i++)
            if (push && CW'(i) < push_n) begin
               inst_q[tail_q + PW'(i)] <= ic_inst[i*INST +: INST];
               pc_q[tail_q + PW'(i)]   <= ic_pc + ADDR'(4 * i);
            end
      end
   end
   for (genvar j = 0; j < DEC; j++) begin : g_dec
      assign dec_inst[j*INST +: INST] = inst_q[head_q + PW'(j)];
      assign dec_pc[j*ADDR +: ADDR]   = pc_q[head_q + PW'(j)];
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven vectors plus a queue scoreboard for fetch_queue
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        reset_ = 1'b1;
   logic        flush_ = 1'b1;
   logic        ic_e_ = 1'b1;
   logic [31:0] ic_pc = '0;
   logic [63:0] ic_inst = '0;
   logic [1:0]  ic_cnt = '0;
   logic        fq_stall;
   logic [1:0]  dec_cnt;
   logic [63:0] dec_inst;
   logic [63:0] dec_pc;
   logic [1:0]  dec_ack = '0;
   logic [3:0]  fq_count;
   int n_cmp = 0;
   int n_bad = 0;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;
   ent_t exp_q[$];
   typedef struct {
      logic        e;
      logic        f;
      logic [31:0] pc;
      logic [1:0]  cnt;
      logic [1:0]  ack;
      int          cnt_exp;
      logic        stall_exp;
      int          dec_exp;
   } vec_t;
   vec_t vecs[19];
   fetch_queue #(.ADDR(32), .INST(32), .FETCH(2), .DEC(2), .DEPTH(8)) dut (
      .clk(clk), .reset_(reset_), .flush_(flush_), .ic_e_(ic_e_), .ic_pc(ic_pc),
      .ic_inst(ic_inst), .ic_cnt(ic_cnt), .fq_stall(fq_stall), .dec_cnt(dec_cnt),
      .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ack(dec_ack), .fq_count(fq_count)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]} ^ 32'h5A5A_0000;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_slots();
      int dc = exp_q.size() < 2 ? exp_q.size() : 2;
      for (int j = 0; j < dc; j++) begin
         chk($sformatf("dec_pc[%0d]", j), dec_pc[j*32 +: 32], exp_q[j].pc);
         chk($sformatf("dec_inst[%0d]", j), dec_inst[j*32 +: 32], exp_q[j].inst);
      end
   endtask
   // Drive one cycle at posedge+1, apply the model at the edge, then compare presented slots.
   task automatic step(input logic e, input logic f, input logic [31:0] pc, input logic [1:0] cnt,
                       input logic [1:0] ack);
      int sz = exp_q.size();
      int dc = sz < 2 ? sz : 2;
      int pop = int'(ack) < dc ? int'(ack) : dc;
      bit acc = !e && f && (8 - sz) >= 2;
      int n = cnt > 2 ? 2 : int'(cnt);
      ic_e_ = e;
      flush_ = f;
      ic_pc = pc;
      ic_cnt = cnt;
      dec_ack = ack;
      ic_inst = {inst_of(pc + 32'd4), inst_of(pc)};
      @(posedge clk);
      #1;
      if (!f) exp_q.delete();
      else begin
         repeat (pop) void'(exp_q.pop_front());
         if (acc)
            for (int i = 0; i < n; i++) exp_q.push_back('{pc + 32'(4 * i), inst_of(pc + 32'(4 * i))});
      end
      chk_slots();
   endtask
   initial begin
      vecs = '{
         '{1'b0, 1'b1, 32'h100,      2'd2, 2'd0, 2, 1'b0, 2},
         '{1'b0, 1'b1, 32'h108,      2'd2, 2'd0, 4, 1'b0, 2},
         '{1'b1, 1'b1, 32'h0,        2'd0, 2'd1, 3, 1'b0, 2},
         '{1'b1, 1'b1, 32'h0,        2'd0, 2'd3, 1, 1'b0, 1},
         '{1'b1, 1'b1, 32'h0,        2'd0, 2'd1, 0, 1'b0, 0},
         '{1'b1, 1'b1, 32'h0,        2'd0, 2'd2, 0, 1'b0, 0},
         '{1'b0, 1'b1, 32'h200,      2'd2, 2'd0, 2, 1'b0, 2},
         '{1'b0, 1'b1, 32'h208,      2'd2, 2'd0, 4, 1'b0, 2},
         '{1'b0, 1'b1, 32'h210,      2'd2, 2'd0, 6, 1'b0, 2},
         '{1'b0, 1'b1, 32'h218,      2'd2, 2'd0, 8, 1'b1, 2},
         '{1'b0, 1'b1, 32'h220,      2'd2, 2'd0, 8, 1'b1, 2},
         '{1'b1, 1'b1, 32'h0,        2'd0, 2'd2, 6, 1'b0, 2},
         '{1'b0, 1'b1, 32'h300,      2'd1, 2'd2, 5, 1'b0, 2},
         '{1'b0, 1'b1, 32'h400,      2'd3, 2'd0, 7, 1'b1, 2},
         '{1'b0, 1'b0, 32'h500,      2'd2, 2'd2, 0, 1'b0, 0},
         '{1'b0, 1'b1, 32'h200,      2'd2, 2'd0, 2, 1'b0, 2},
         '{1'b0, 1'b1, 32'hFFFF_FFFC, 2'd2, 2'd2, 2, 1'b0, 2},
         '{1'b1, 1'b1, 32'h0,        2'd0, 2'd2, 0, 1'b0, 0},
         '{1'b0, 1'b1, 32'h0,        2'd0, 2'd0, 0, 1'b0, 0}
      };
      #2 reset_ = 1'b0;
      #1;
      chk("reset fq_count", 32'(fq_count), 32'd0);
      chk("reset fq_stall", 32'(fq_stall), 32'd0);
      chk("reset dec_cnt", 32'(dec_cnt), 32'd0);
      chk("reset dec_pc", dec_pc[31:0], 32'd0);
      chk("reset dec_inst", dec_inst[63:32], 32'd0);
      @(negedge clk) reset_ = 1'b1;
      @(posedge clk);
      #1;
      foreach (vecs[k]) begin
         step(vecs[k].e, vecs[k].f, vecs[k].pc, vecs[k].cnt, vecs[k].ack);
         chk($sformatf("v%0d fq_count", k), 32'(fq_count), 32'(vecs[k].cnt_exp));
         chk($sformatf("v%0d fq_stall", k), 32'(fq_stall), 32'(vecs[k].stall_exp));
         chk($sformatf("v%0d dec_cnt", k), 32'(dec_cnt), 32'(vecs[k].dec_exp));
      end
      // Streaming push 2 / ack 2 across several pointer wraps.
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b1, 32'(8 * k), 2'd2, 2'd2);
         chk($sformatf("stream%0d fq_count", k), 32'(fq_count), 32'd2);
         chk($sformatf("stream%0d dec_pc0", k), dec_pc[31:0], 32'(8 * k));
      end
      step(1'b1, 1'b1, 32'h0, 2'd0, 2'd2);
      chk("drain fq_count", 32'(fq_count), 32'd0);
      // Asynchronous reset between edges while a push is being offered.
      step(1'b0, 1'b1, 32'h600, 2'd2, 2'd0);
      step(1'b0, 1'b1, 32'h608, 2'd2, 2'd0);
      step(1'b0, 1'b1, 32'h610, 2'd1, 2'd0);
      chk("pre-reset fq_count", 32'(fq_count), 32'd5);
      ic_pc = 32'h700;
      #2 reset_ = 1'b0;
      #1;
      chk("async fq_count", 32'(fq_count), 32'd0);
      chk("async dec_cnt", 32'(dec_cnt), 32'd0);
      chk("async fq_stall", 32'(fq_stall), 32'd0);
      chk("async dec_pc", dec_pc[31:0], 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset_ = 1'b1;
      ic_e_ = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset fq_count", 32'(fq_count), 32'd0);
      step(1'b0, 1'b1, 32'h700, 2'd1, 2'd0);
      chk("post-reset push count", 32'(fq_count), 32'd1);
      chk("post-reset push pc", dec_pc[31:0], 32'h700);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
